// File: rtl/skid_register_if.sv
// Handshake bundle for skid_register: producer side (in_*), reader side (out_*)
// and the occupancy count. The register itself attaches through the slave modport.
interface skid_register_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   level;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output level
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  level
    );
endinterface

// File: rtl/skid_register.sv
// Two-entry pipeline register with valid/ready on both sides. in_ready comes
// straight from a flop, so no combinational path runs from out_ready to in_ready.
module skid_register #(
    parameter int           N           = 4,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic           clock,
    input  logic           reset,
    skid_register_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b01,
        FULL2 = 2'b10
    } state_t;

    // State together with the outputs it decodes to, so every output is a flop.
    typedef struct packed {
        state_t     state;
        logic       out_valid;
        logic       in_ready;
        logic [1:0] level;
    } fsm_t;

    function automatic fsm_t decode(input state_t s);
        fsm_t f;
        f.state     = s;
        f.out_valid = 1'b0;
        f.in_ready  = 1'b1;
        f.level     = 2'd0;
        case (s)
            FULL1: begin
                f.out_valid = 1'b1;
                f.in_ready  = 1'b1;
                f.level     = 2'd1;
            end
            FULL2: begin
                f.out_valid = 1'b1;
                f.in_ready  = 1'b0;
                f.level     = 2'd2;
            end
            default: begin
                f.state     = EMPTY;
                f.out_valid = 1'b0;
                f.in_ready  = 1'b1;
                f.level     = 2'd0;
            end
        endcase
        return f;
    endfunction

    fsm_t         fsm_reg;
    logic [N-1:0] main_reg;
    logic [N-1:0] skid_reg;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = bus.in_valid & fsm_reg.in_ready;
    assign out_fire = bus.out_ready & fsm_reg.out_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_reg  <= decode(EMPTY);
            main_reg <= RESET_VALUE;
            skid_reg <= RESET_VALUE;
        end else begin
            case (fsm_reg.state)
                EMPTY: begin
                    if (in_fire) begin
                        main_reg <= bus.in_data;
                        fsm_reg  <= decode(FULL1);
                    end
                end
                FULL1: begin
                    if (in_fire && out_fire) begin
                        main_reg <= bus.in_data;
                    end else if (in_fire) begin
                        // Reader stalled: park the newer word behind main.
                        skid_reg <= bus.in_data;
                        fsm_reg  <= decode(FULL2);
                    end else if (out_fire) begin
                        fsm_reg  <= decode(EMPTY);
                    end
                end
                FULL2: begin
                    if (out_fire) begin
                        main_reg <= skid_reg;
                        fsm_reg  <= decode(FULL1);
                    end
                end
                default: begin
                    fsm_reg <= decode(EMPTY);
                end
            endcase
        end
    end

    assign bus.in_ready  = fsm_reg.in_ready;
    assign bus.out_valid = fsm_reg.out_valid;
    assign bus.out_data  = main_reg;
    assign bus.level     = fsm_reg.level;
endmodule
